// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to TX and RX),
// oversampling ratio and the baud divisor used on the bench.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int OVERSAMPLE     = 16;
  localparam int BENCH_BAUD_DIV = 25;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the producer and the UART transmitter.
// Signal names follow the transmitter's point of view.
interface uart_tx_if #(
  parameter int NB_DATA = 8
) ();
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;

  modport master (output i_data, output i_valid, input  o_ready);
  modport slave  (input  i_data, input  i_valid, output o_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity,
// SB_TICK ticks of stop, all timed by the shared 16x oversampling tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_tick,
  uart_tx_if.slave  s_if,
  output logic      o_tx,
  output logic      o_done
);

  // Tick counter must reach the longer of a data bit and the stop period.
  localparam int TW = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [TW-1:0] TBIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TSTOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NB_DATA - 1);
  localparam logic          PAR_INIT   = (PARITY_ODD != 0);
  localparam bit            HAS_PAR    = (PARITY_EN != 0);

  uart_state_e        r_state;
  logic [TW-1:0]      r_tcnt;
  logic [BW-1:0]      r_nbit;
  logic [NB_DATA-1:0] r_shift;
  logic               r_par;
  logic               r_tx;
  logic               r_ready;
  logic               r_done;

  logic w_hs;
  logic w_bit_end;
  logic w_stop_end;
  logic w_last_bit;

  assign w_hs       = s_if.i_valid & r_ready;
  assign w_bit_end  = i_tick & (r_tcnt == TBIT_LAST);
  assign w_stop_end = i_tick & (r_tcnt == TSTOP_LAST);
  assign w_last_bit = (r_nbit == BIT_LAST);

  assign s_if.o_ready = r_ready;
  assign o_tx         = r_tx;
  assign o_done       = r_done;

  // Frame sequencer; o_tx is loaded with the level of the state being entered
  // so the line changes on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_nbit  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Ticks are ignored here; the start bit is timed from the handshake.
          if (w_hs) begin
            r_shift <= s_if.i_data;
            r_tcnt  <= '0;
            r_nbit  <= '0;
            r_par   <= PAR_INIT;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tcnt  <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else if (i_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_tcnt  <= '0;
            r_shift <= r_shift >> 1;
            r_par   <= r_par ^ r_shift[0];
            r_nbit  <= r_nbit + 1'b1;
            if (!w_last_bit) begin
              r_tx <= r_shift[1];
            end else if (HAS_PAR) begin
              r_tx    <= r_par ^ r_shift[0];
              r_state <= ST_PARITY;
            end else begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end
          end else if (i_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_tcnt  <= '0;
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end else if (i_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_stop_end) begin
            r_tcnt  <= '0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else if (i_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: begin
          r_tcnt  <= '0;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (plain 8N1, 8E2, 8O1.5) share clock,
// reset and a divide-by-25 tick. A per-cycle frame model derived from the
// tick count since each handshake predicts o_tx/o_ready/o_done, and a
// mid-bit sampling receiver recovers the byte, parity and stop length.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int NI = 3;
  localparam int SB_T [NI] = '{16, 32, 24};
  localparam int PE   [NI] = '{0, 1, 1};
  localparam int PO   [NI] = '{0, 0, 1};

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [7:0] exp_rx;
    logic       chk_par;
    logic       exp_par;
    int         exp_stop;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  int   tdiv = 0;

  logic       vld [NI];
  logic [7:0] dat [NI];
  logic       manual, m_vld;
  logic [7:0] m_dat;
  logic       tx_a [NI], rdy_a [NI], done_a [NI];

  logic [7:0] sbuf [NI][128];
  int         wp [NI], rp [NI];

  logic       busy [NI];
  int         k [NI];
  logic [7:0] fdat [NI], rx_b [NI], rx_last [NI];
  logic       rx_p [NI], par_last [NI];
  int         done_cnt [NI], done_cyc [NI], gap [NI], stop_n [NI], stop_last [NI];
  int         cyc, ntests, nfail;

  vec_t tbl [6];

  uart_tx_if #(.NB_DATA(8)) if0 ();
  uart_tx_if #(.NB_DATA(8)) if1 ();
  uart_tx_if #(.NB_DATA(8)) if2 ();

  assign if0.i_valid = vld[0];  assign if0.i_data = dat[0];  assign rdy_a[0] = if0.o_ready;
  assign if1.i_valid = vld[1];  assign if1.i_data = dat[1];  assign rdy_a[1] = if1.o_ready;
  assign if2.i_valid = vld[2];  assign if2.i_data = dat[2];  assign rdy_a[2] = if2.o_ready;

  uart_tx #(.NB_DATA(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .s_if(if0.slave), .o_tx(tx_a[0]), .o_done(done_a[0]));
  uart_tx #(.NB_DATA(8), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .s_if(if1.slave), .o_tx(tx_a[1]), .o_done(done_a[1]));
  uart_tx #(.NB_DATA(8), .SB_TICK(24), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .s_if(if2.slave), .o_tx(tx_a[2]), .o_done(done_a[2]));

  always #5 clk = ~clk;

  // Baud tick: one cycle in every BENCH_BAUD_DIV, changed away from the active edge.
  always @(negedge clk) begin
    if (tdiv == BENCH_BAUD_DIV - 1) begin tdiv = 0; tick = 1'b1; end
    else begin tdiv = tdiv + 1; tick = 1'b0; end
  end

  // Producers: each instance drains its byte queue; instance 0 can be driven by hand.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (i == 0 && manual) begin
        vld[0] = m_vld;
        dat[0] = m_dat;
      end else begin
        vld[i] = (rp[i] < wp[i]);
        dat[i] = (rp[i] < wp[i]) ? sbuf[i][rp[i]] : 8'h00;
      end
    end
  end

  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  endtask

  task automatic check_int(input string nm, input int i, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d] cyc %0d: got %0d want %0d", nm, i, cyc, act, exp);
      if (nfail >= 100) begin
        $display("FAIL abort: too many errors");
        summary_and_finish();
      end
    end
  endtask

  task automatic check_bit(input string nm, input int i, input logic act, input logic exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s[%0d] cyc %0d: got %b want %b", nm, i, cyc, act, exp);
      if (nfail >= 100) begin
        $display("FAIL abort: too many errors");
        summary_and_finish();
      end
    end
  endtask

  // Frame model: after a handshake the line is bit (ticks_seen / 16) of
  // {start, data LSB first, parity} and high afterwards; the frame ends when
  // 16*(9+PE)+SB ticks have been counted.
  task automatic monitor();
    int   idx, tot;
    logic etx, edone;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NI; i++) begin
        tot   = 16 * (9 + PE[i]) + SB_T[i];
        edone = 1'b0;
        if (rst) begin
          busy[i] = 1'b0;
        end else if (!busy[i]) begin
          if (vld[i]) begin
            busy[i] = 1'b1; k[i] = 0; fdat[i] = dat[i];
            gap[i] = cyc - done_cyc[i]; stop_n[i] = 0; rx_b[i] = 8'h00; rx_p[i] = 1'b0;
            if (!(i == 0 && manual)) rp[i]++;
          end
        end else begin
          if (tick) k[i]++;
          if (k[i] == tot) begin
            busy[i] = 1'b0; edone = 1'b1; done_cnt[i]++; done_cyc[i] = cyc;
            rx_last[i] = rx_b[i]; par_last[i] = rx_p[i]; stop_last[i] = stop_n[i];
          end
        end
        etx = 1'b1;
        if (busy[i]) begin
          idx = k[i] / 16;
          if (idx == 0) etx = 1'b0;
          else if (idx <= 8) etx = fdat[i][idx-1];
          else if (idx == 9 && PE[i] != 0) etx = (^fdat[i]) ^ (PO[i] != 0);
          if (idx >= 9 + PE[i] && tx_a[i] === 1'b1) stop_n[i]++;
          if (tick && (k[i] % 16) == 8) begin
            if (idx >= 1 && idx <= 8) rx_b[i][idx-1] = tx_a[i];
            if (idx == 9 && PE[i] != 0) rx_p[i] = tx_a[i];
          end
        end
        check_bit("tx", i, tx_a[i], etx);
        check_bit("ready", i, rdy_a[i], !busy[i]);
        check_bit("done", i, done_a[i], edone);
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    sbuf[i][wp[i]] = d;
    wp[i]++;
  endtask

  task automatic wait_frames(input int i, input int n, input int limit);
    int c;
    c = 0;
    while (done_cnt[i] < n && c < limit) begin @(posedge clk); #2; c++; end
    check_int("frames_done", i, done_cnt[i], n);
  endtask

  initial begin
    int n, c;
    int base [NI];
    manual = 1'b0; m_vld = 1'b0; m_dat = 8'h00;
    cyc = 0; ntests = 0; nfail = 0;
    for (int i = 0; i < NI; i++) begin
      wp[i] = 0; rp[i] = 0; busy[i] = 1'b0; k[i] = 0; fdat[i] = 8'h00;
      done_cnt[i] = 0; done_cyc[i] = 0; gap[i] = 0; stop_n[i] = 0; stop_last[i] = 0;
      rx_b[i] = 8'h00; rx_last[i] = 8'h00; rx_p[i] = 1'b0; par_last[i] = 1'b0;
    end
    tbl[0] = '{0, 8'h48, 8'h48, 1'b0, 1'b0, 400};
    tbl[1] = '{0, 8'hFF, 8'hFF, 1'b0, 1'b0, 400};
    tbl[2] = '{1, 8'h07, 8'h07, 1'b1, 1'b1, 800};
    tbl[3] = '{2, 8'h07, 8'h07, 1'b1, 1'b0, 600};
    tbl[4] = '{1, 8'hA5, 8'hA5, 1'b1, 1'b0, 800};
    tbl[5] = '{2, 8'h00, 8'h00, 1'b1, 1'b1, 600};

    fork monitor(); join_none

    // Reset held for 5 cycles, then idle with i_valid low.
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_bit("idle_tx", i, tx_a[i], 1'b1);
      check_bit("idle_ready", i, rdy_a[i], 1'b1);
      check_int("idle_done_cnt", i, done_cnt[i], 0);
    end

    // Table of single frames across the three configurations.
    for (int v = 0; v < 6; v++) begin
      n = done_cnt[tbl[v].inst] + 1;
      @(negedge clk);
      push(tbl[v].inst, tbl[v].data);
      wait_frames(tbl[v].inst, n, 7000);
      check_int("rx_byte", tbl[v].inst, int'(rx_last[tbl[v].inst]), int'(tbl[v].exp_rx));
      if (tbl[v].chk_par)
        check_bit("rx_parity", tbl[v].inst, par_last[tbl[v].inst], tbl[v].exp_par);
      check_int("stop_clks", tbl[v].inst, stop_last[tbl[v].inst], tbl[v].exp_stop);
    end

    // Back-to-back: second handshake one cycle after o_done.
    n = done_cnt[0];
    @(negedge clk);
    push(0, 8'h55); push(0, 8'hAA);
    wait_frames(0, n + 2, 9000);
    check_int("b2b_rx", 0, int'(rx_last[0]), 8'hAA);
    check_int("b2b_gap", 0, gap[0], 1);

    // Reset in the middle of data bit 3 of 0xFF.
    n = done_cnt[0];
    @(negedge clk); manual = 1'b1; m_vld = 1'b1; m_dat = 8'hFF;
    c = 0;
    while (rdy_a[0] !== 1'b0 && c < 50) begin @(posedge clk); #2; c++; end
    check_bit("mr_accept", 0, rdy_a[0], 1'b0);
    @(negedge clk); m_vld = 1'b0;
    c = 0;
    while (k[0] != 72 && c < 3000) begin @(posedge clk); #2; c++; end
    check_int("mr_reach_bit3", 0, k[0], 72);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #2;
    check_bit("mr_tx", 0, tx_a[0], 1'b1);
    check_bit("mr_ready", 0, rdy_a[0], 1'b1);
    @(negedge clk); rst = 1'b0; manual = 1'b0;
    repeat (3) @(negedge clk);
    check_int("mr_no_done", 0, done_cnt[0], n);
    push(0, 8'h48);
    wait_frames(0, n + 1, 7000);
    check_int("mr_rx", 0, int'(rx_last[0]), 8'h48);

    // i_data / i_valid churn during a frame of 0x3C.
    n = done_cnt[0];
    @(negedge clk); manual = 1'b1; m_vld = 1'b1; m_dat = 8'h3C;
    c = 0;
    while (rdy_a[0] !== 1'b0 && c < 50) begin @(posedge clk); #2; c++; end
    check_bit("ig_accept", 0, rdy_a[0], 1'b0);
    repeat (3000) begin
      @(negedge clk); m_vld = 1'($urandom); m_dat = 8'($urandom);
    end
    m_vld = 1'b0;
    wait_frames(0, n + 1, 7000);
    check_int("ig_rx", 0, int'(rx_last[0]), 8'h3C);
    @(negedge clk); manual = 1'b0;
    repeat (5) @(negedge clk);
    check_int("ig_single_frame", 0, done_cnt[0], n + 1);

    // Random bytes to all instances with random gaps between batches.
    for (int i = 0; i < NI; i++) base[i] = done_cnt[i];
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) push(i, 8'($urandom));
      repeat ($urandom_range(0, 2000)) @(negedge clk);
    end
    for (int i = 0; i < NI; i++) wait_frames(i, base[i] + 3, 20000);

    repeat (10) @(negedge clk);
    summary_and_finish();
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit end of the link whose receive side feeds the BIP processor.
- Takes one parallel byte per valid/ready handshake from the processor's output path.
- Serialises it as start bit, NB_DATA data bits LSB first, optional parity, then stop bit(s) on o_tx.
- Bit timing comes from the shared 16x-oversampling baud tick, the same i_tick the receiver uses.

Parameters:
- NB_DATA, 8, data bits per frame (5..9)
- SB_TICK, 16, stop-bit length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- PARITY_EN, 0, 1 inserts a parity bit after the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

Ports:
- i_clk  input  1  system clock; all logic on its rising edge
- i_rst  input  1  synchronous, active-high reset
- i_tick  input  1  one-cycle pulse at 16x baud rate from the shared baud generator
- i_data  input  NB_DATA  byte to send; sampled only at handshake
- i_valid  input  1  producer has a byte on i_data
- o_ready  output  1  high only in IDLE; a transfer occurs when i_valid && o_ready at a rising edge
- o_tx  output  1  serial line, registered, idles high
- o_done  output  1  one-cycle pulse when the final stop tick completes

Behaviour:
- Reset: state = IDLE, o_tx = 1, o_ready = 1, o_done = 0, tick counter = 0, bit counter = 0, shift register = 0.
- Reset taken mid-frame aborts the frame immediately; o_tx returns to 1 on the next edge.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: o_tx = 1, o_ready = 1.
  - On handshake: i_data goes into the shift register, tick counter = 0, bit counter = 0, parity accumulator = PARITY_ODD.
  - Next state is START; o_tx = 0 and o_ready = 0 from the following cycle.
  - i_tick is ignored in IDLE.
- START: counts i_tick. On the tick where the counter = 15: counter clears and state goes to DATA.
  - The start bit therefore lasts from the handshake until the 16th tick after it.
- DATA: o_tx = shift[0].
  - On the 16th tick: shift right one place, XOR the sent bit into parity, increment the bit counter.
  - After bit NB_DATA-1: go to PARITY if PARITY_EN, otherwise to STOP.
- PARITY: o_tx = parity accumulator for 16 ticks, then STOP.
- STOP: o_tx = 1 for SB_TICK ticks.
  - On the tick where the counter = SB_TICK-1: state goes to IDLE and o_done pulses for exactly one cycle.
  - o_ready rises in the same cycle as o_done.
- Back-to-back: a byte presented with i_valid already high is accepted on the first IDLE cycle. There is no idle gap beyond that single cycle.
- i_valid during a frame: no effect; the producer must hold the byte until o_ready.
- i_data changes after the handshake do not affect the frame in flight.
- Tick counter width: enough bits for max(16, SB_TICK)-1. It wraps only by explicit clear, never by overflow.
- Frame length in ticks: 16 x (1 + NB_DATA + PARITY_EN) + SB_TICK.
  - Default: 160 ticks, which is 4000 clocks at the bench divisor of 25 (400 clocks per bit).

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE/START/DATA/PARITY/STOP), shared with the receiver;
  - the oversampling constant OVERSAMPLE = 16;
  - the bench baud divisor constant.
- No sub-module. i_tick comes from the existing baud-rate generator, instanced once in Top and shared by the receiver and this block.
- Top connects o_tx to UART_RXD_OUT.

Test Plan:
1. Reset behaviour: hold i_rst for 5 cycles, release with i_valid = 0 -> o_tx = 1 and o_ready = 1 throughout; o_done never pulses.
2. Single byte: send 0x48 with the bench divisor 25.
   - o_tx = 0 for 400 clocks, then bits 0,0,0,1,0,0,1,0 at 400 clocks each, then 1 for 400 clocks.
   - o_done pulses once, about 4000 clocks after the handshake.
   - A looped-back receiver returns 0x48.
3. Back-to-back: send 0x55 then 0xAA with i_valid held high -> second start bit begins one cycle after o_done; line pattern is exact, with no extra idle.
4. Parity and stop length: PARITY_EN = 1, PARITY_ODD = 0, send 0x07 -> parity bit 1; PARITY_ODD = 1 -> parity bit 0; SB_TICK = 32 -> stop high for 800 clocks.
5. Mid-frame reset: assert i_rst during data bit 3 of 0xFF -> o_tx = 1 the next cycle, state IDLE, o_ready = 1, no o_done; a following 0x48 transmits correctly.
6. Ignored inputs: toggle i_data and i_valid during a frame of 0x3C -> the line carries 0x3C exactly; no second frame starts until o_ready is high.
